// File: rtl/flash_access_arbiter_if.sv
// rtl/flash_access_arbiter_if.sv - request, flash handshake and grant bundle for the flash access arbiter
interface flash_access_arbiter_if;
    logic [3:0] iREQ;
    logic       iFL_Start;
    logic       iFL_Ready;
    logic [1:0] oSelect;
    logic [3:0] oGNT;
    logic       oBusy;
    logic       oTimeout;

    // Arbiter side: consumes requests and flash status, drives select and grants
    modport slave (
        input  iREQ,
        input  iFL_Start,
        input  iFL_Ready,
        output oSelect,
        output oGNT,
        output oBusy,
        output oTimeout
    );

    // Requester / flash side
    modport master (
        output iREQ,
        output iFL_Start,
        output iFL_Ready,
        input  oSelect,
        input  oGNT,
        input  oBusy,
        input  oTimeout
    );
endinterface

// File: rtl/flash_access_arbiter.sv
// rtl/flash_access_arbiter.sv - round-robin arbiter and sequencer for the shared 8-bit flash port
module flash_access_arbiter #(
    parameter int GUARD_CYCLES = 2,
    parameter int TIMEOUT      = 50000
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    flash_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWITCH  = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0]  GUARD_LOAD = 4'(GUARD_CYCLES);
    localparam logic [19:0] WDOG_LAST  = 20'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  last;
    logic [1:0]  winner;
    logic [3:0]  guardCnt;
    logic [19:0] wdogCnt;

    logic [1:0]  nextWinner;
    logic        anyReq;
    logic        completion;
    logic        wdogExpired;

    // Round-robin search: scan from the farthest slot to the nearest so the
    // requester closest after `last` overwrites the others and wins.
    always_comb begin
        logic [1:0] cand;
        nextWinner = last;
        cand       = last;
        for (int i = 3; i >= 0; i--) begin
            cand = last + 2'(i + 1);
            if (bus.iREQ[cand]) begin
                nextWinner = cand;
            end
        end
    end

    // The mux latches read data in the cycle start and ready coincide
    assign anyReq      = |bus.iREQ;
    assign completion  = bus.iFL_Start & bus.iFL_Ready;
    assign wdogExpired = (wdogCnt == WDOG_LAST);

    // Arbitration FSM with registered select, grant, busy and timeout outputs
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state        <= IDLE;
            last         <= 2'd3;
            winner       <= 2'd0;
            guardCnt     <= 4'd0;
            wdogCnt      <= 20'd0;
            bus.oSelect  <= 2'd0;
            bus.oGNT     <= 4'd0;
            bus.oBusy    <= 1'b0;
            bus.oTimeout <= 1'b0;
        end else begin
            bus.oTimeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        winner      <= nextWinner;
                        bus.oSelect <= nextWinner;
                        guardCnt    <= GUARD_LOAD;
                        bus.oBusy   <= 1'b1;
                        state       <= SWITCH;
                    end
                end

                SWITCH: begin
                    // Requests may drop here; the grant is issued regardless
                    guardCnt <= guardCnt - 4'd1;
                    if (guardCnt <= 4'd1) begin
                        bus.oGNT <= 4'b0001 << winner;
                        last     <= winner;
                        wdogCnt  <= 20'd0;
                        state    <= GRANT;
                    end
                end

                GRANT: begin
                    if (winner == 2'd0) begin
                        // Host owns the flash for as long as it asks; erases are unbounded
                        if (!bus.iREQ[0]) begin
                            bus.oGNT <= 4'd0;
                            state    <= RELEASE;
                        end
                    end else if (completion) begin
                        // Completion beats a simultaneous watchdog expiry
                        bus.oGNT <= 4'd0;
                        state    <= RELEASE;
                    end else if (wdogExpired) begin
                        // Dropping select to 0 resets the mux read sequencer
                        bus.oTimeout <= 1'b1;
                        bus.oGNT     <= 4'd0;
                        bus.oSelect  <= 2'd0;
                        bus.oBusy    <= 1'b0;
                        wdogCnt      <= 20'd0;
                        state        <= IDLE;
                    end else begin
                        wdogCnt <= wdogCnt + 20'd1;
                    end
                end

                RELEASE: begin
                    // Hold select until the controller has dropped start
                    if (!bus.iFL_Start) begin
                        if (anyReq) begin
                            winner      <= nextWinner;
                            bus.oSelect <= nextWinner;
                            guardCnt    <= GUARD_LOAD;
                            state       <= SWITCH;
                        end else begin
                            bus.oSelect <= 2'd0;
                            bus.oBusy   <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end

                default: begin
                    bus.oGNT    <= 4'd0;
                    bus.oSelect <= 2'd0;
                    bus.oBusy   <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_access_arbiter.sv
// tb/tb_flash_access_arbiter.sv - directed table-driven bench for flash_access_arbiter
module tb_flash_access_arbiter;

    localparam int G = 2;
    localparam int T = 100;

    logic iCLK;
    logic iRST_n;

    flash_access_arbiter_if bus ();

    flash_access_arbiter #(
        .GUARD_CYCLES(G),
        .TIMEOUT     (T)
    ) dut (
        .iCLK  (iCLK),
        .iRST_n(iRST_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] req;
        logic       st;
        logic       rdy;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       busy;
    } vec_t;

    int nVec  = 0;
    int nMiss = 0;
    vec_t vecs [41];

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 300000");
        $fatal(1);
    end

    // Guard-time monitor: no grant while select changed within the last G cycles
    logic [1:0] prevSel = 2'd0;
    int         since   = G;
    always @(negedge iCLK) begin
        if (!iRST_n) begin
            prevSel = 2'd0;
            since   = G;
        end else begin
            if (bus.oSelect != prevSel) since = 0;
            else if (since < 1000) since = since + 1;
            prevSel = bus.oSelect;
            if (bus.oGNT != 4'd0 && since < G) begin
                nMiss = nMiss + 1;
                $display("FAIL guard_time: gnt=%b %0d cycles after select change, required >= %0d", bus.oGNT, since, G);
            end
        end
    end

    function automatic logic [7:0] outs();
        return {bus.oSelect, bus.oGNT, bus.oBusy, bus.oTimeout};
    endfunction

    function automatic logic [7:0] mk(input logic [1:0] s, input logic [3:0] g, input logic b, input logic t);
        return {s, g, b, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec = nVec + 1;
        if (act !== exp) begin
            nMiss = nMiss + 1;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic setIn(input logic [3:0] r, input logic s, input logic d);
        bus.iREQ      = r;
        bus.iFL_Start = s;
        bus.iFL_Ready = d;
    endtask

    initial begin
        logic ok;

        //             req      st    rdy   sel   gnt      busy
        vecs[0]  = '{4'b1110, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1};
        vecs[1]  = '{4'b1110, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1};
        vecs[2]  = '{4'b1110, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[3]  = '{4'b1110, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[4]  = '{4'b1110, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1};
        vecs[5]  = '{4'b1110, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        vecs[6]  = '{4'b1110, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        vecs[7]  = '{4'b1110, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1};
        vecs[8]  = '{4'b1110, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b1};
        vecs[9]  = '{4'b1110, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1};
        vecs[10] = '{4'b1110, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b1};
        vecs[11] = '{4'b1110, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b1};
        vecs[12] = '{4'b1110, 1'b0, 1'b0, 2'd3, 4'b1000, 1'b1};
        vecs[13] = '{4'b1110, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b1};
        vecs[14] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[15] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[16] = '{4'b1000, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b1};
        vecs[17] = '{4'b1000, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b1};
        vecs[18] = '{4'b1000, 1'b0, 1'b0, 2'd3, 4'b1000, 1'b1};
        vecs[19] = '{4'b0000, 1'b1, 1'b0, 2'd3, 4'b1000, 1'b1};
        vecs[20] = '{4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b1};
        vecs[21] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[22] = '{4'b0100, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        vecs[23] = '{4'b0100, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        vecs[24] = '{4'b0100, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1};
        vecs[25] = '{4'b0100, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b1};
        vecs[26] = '{4'b0100, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        vecs[27] = '{4'b0100, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1};
        vecs[28] = '{4'b0100, 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1};
        vecs[29] = '{4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b1};
        vecs[30] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[31] = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        vecs[32] = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        vecs[33] = '{4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1};
        vecs[34] = '{4'b0011, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1};
        vecs[35] = '{4'b0010, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1};
        vecs[36] = '{4'b0010, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1};
        vecs[37] = '{4'b0010, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1};
        vecs[38] = '{4'b0010, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b1};
        vecs[39] = '{4'b0000, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b1};
        vecs[40] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0};

        // Reset with every requester asking
        iRST_n = 1'b0;
        setIn(4'b1111, 1'b0, 1'b0);
        repeat (3) @(posedge iCLK);
        #1;
        chk("reset_outputs", 32'(outs()), 32'(mk(2'd0, 4'b0000, 1'b0, 1'b0)));
        iRST_n = 1'b1;
        tick();
        chk("post_reset_edge1", 32'(outs()), 32'(mk(2'd0, 4'b0000, 1'b1, 1'b0)));
        tick();
        chk("post_reset_edge2", 32'(bus.oGNT), 32'(4'b0000));
        tick();
        chk("post_reset_host_grant", 32'(outs()), 32'(mk(2'd0, 4'b0001, 1'b1, 1'b0)));

        // Host holds the flash for 1000 cycles with requester 1 waiting
        setIn(4'b0011, 1'b0, 1'b0);
        ok = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (bus.oGNT !== 4'b0001 || bus.oTimeout !== 1'b0) ok = 1'b0;
        end
        chk("host_hold_1000", 32'(ok), 32'(1'b1));
        setIn(4'b0010, 1'b0, 1'b0);
        tick();
        chk("host_drop_gnt_low", 32'(outs()), 32'(mk(2'd0, 4'b0000, 1'b1, 1'b0)));
        tick();
        chk("host_drop_sel1", 32'(outs()), 32'(mk(2'd1, 4'b0000, 1'b1, 1'b0)));
        tick();
        chk("host_drop_guard", 32'(bus.oGNT), 32'(4'b0000));
        tick();
        chk("host_drop_gnt1", 32'(outs()), 32'(mk(2'd1, 4'b0010, 1'b1, 1'b0)));

        // Reset while the async read is mid-flight: outputs clear with no edge
        setIn(4'b0010, 1'b1, 1'b0);
        tick();
        chk("async_inflight", 32'(bus.oGNT), 32'(4'b0010));
        #2;
        iRST_n = 1'b0;
        #1;
        chk("async_reset_immediate", 32'(outs()), 32'(mk(2'd0, 4'b0000, 1'b0, 1'b0)));
        @(negedge iCLK);
        setIn(4'b1111, 1'b0, 1'b0);
        iRST_n = 1'b1;
        tick();
        chk("restart_sel0", 32'(outs()), 32'(mk(2'd0, 4'b0000, 1'b1, 1'b0)));
        tick();
        tick();
        chk("restart_from_req0", 32'(bus.oGNT), 32'(4'b0001));

        // Fresh reset so the table starts from IDLE with last=3
        setIn(4'b0000, 1'b0, 1'b0);
        iRST_n = 1'b0;
        tick();
        iRST_n = 1'b1;

        for (int i = 0; i < 41; i++) begin
            setIn(vecs[i].req, vecs[i].st, vecs[i].rdy);
            tick();
            chk($sformatf("vec[%0d]", i), 32'(outs()),
                32'(mk(vecs[i].sel, vecs[i].gnt, vecs[i].busy, 1'b0)));
        end

        // Watchdog: requester 2 with ready stuck low (last=1 here)
        setIn(4'b0100, 1'b0, 1'b0);
        tick();
        chk("wd_sel2", 32'(outs()), 32'(mk(2'd2, 4'b0000, 1'b1, 1'b0)));
        tick();
        tick();
        chk("wd_grant", 32'(bus.oGNT), 32'(4'b0100));
        setIn(4'b0100, 1'b1, 1'b0);
        ok = 1'b1;
        for (int k = 1; k < T; k++) begin
            tick();
            if (bus.oTimeout !== 1'b0 || bus.oGNT !== 4'b0100) ok = 1'b0;
        end
        chk("wd_no_early_timeout", 32'(ok), 32'(1'b1));
        tick();
        chk("wd_timeout_pulse", 32'(outs()), 32'(mk(2'd0, 4'b0000, 1'b0, 1'b1)));
        setIn(4'b0100, 1'b0, 1'b0);
        tick();
        chk("wd_pulse_end_regrab", 32'(outs()), 32'(mk(2'd2, 4'b0000, 1'b1, 1'b0)));
        tick();
        tick();
        chk("wd_regrant", 32'(bus.oGNT), 32'(4'b0100));

        // Completion on the same edge the watchdog would expire: completion wins
        setIn(4'b0100, 1'b1, 1'b0);
        ok = 1'b1;
        for (int k = 1; k < T; k++) begin
            tick();
            if (bus.oTimeout !== 1'b0 || bus.oGNT !== 4'b0100) ok = 1'b0;
        end
        chk("tie_hold", 32'(ok), 32'(1'b1));
        setIn(4'b0100, 1'b1, 1'b1);
        tick();
        chk("tie_completion_wins", 32'(outs()), 32'(mk(2'd2, 4'b0000, 1'b1, 1'b0)));
        setIn(4'b0000, 1'b0, 1'b0);
        tick();
        chk("tie_back_idle", 32'(outs()), 32'(mk(2'd0, 4'b0000, 1'b0, 1'b0)));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
